demux_1to4_stream: RTL and testbench

- Registered 1-to-4 demultiplexer; the inverse of the team's 4:1 mux.
- Routes one input word to one of four output channels a/b/c/d using the same select encoding as the mux: {s0,s1} 00->a, 01->b, 10->c, 11->d.
- Each output channel has a one-entry holding slot with a valid/ready handshake, so each downstream consumer can stall on its own.
- Sits between a single producer and four independent consumers.

---
 rtl/demux_pkg.sv | 22 ++
 rtl/demux_slot.sv | 67 ++++++
 rtl/demux_1to4_stream.sv | 128 ++++++++++++
 tb/tb_demux_1to4_stream.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// ============================================================================
// Module  : demux_pkg
// Brief   : Shared channel-select encodings and default widths for the
//           1-to-4 stream demultiplexer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package demux_pkg;

    // Same {s0,s1} encoding as the 4:1 mux this block mirrors.
    localparam logic [1:0] CH_A = 2'b00;
    localparam logic [1:0] CH_B = 2'b01;
    localparam logic [1:0] CH_C = 2'b10;
    localparam logic [1:0] CH_D = 2'b11;

    localparam int DEFAULT_WIDTH = 2;
    localparam int DEFAULT_CNT_W = 8;

endpackage

`default_nettype wire

// File: rtl/demux_slot.sv
// ============================================================================
// Module  : demux_slot
// Brief   : One-entry valid/ready holding slot; a push on the same edge as a
//           pop keeps the slot full. Optional pop counter under DEMUX_CNT_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
`ifdef DEMUX_CNT_EN
    ,
    parameter int CNT_W = DEFAULT_CNT_W
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0] o_cnt
`endif
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             w_pop;

    assign w_pop   = r_valid && i_ready;
    assign o_data  = r_data;
    assign o_valid = r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_push) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (w_pop) begin
            r_valid <= 1'b0;
        end
    end

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_pop) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
`endif

endmodule

`default_nettype wire

// File: rtl/demux_1to4_stream.sv
// ============================================================================
// Module  : demux_1to4_stream
// Brief   : Registered 1-to-4 stream demux with per-channel one-entry slots and
//           a sticky select-change flag. DEMUX_CNT_EN adds pop counters.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module demux_1to4_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
`ifdef DEMUX_CNT_EN
    ,
    parameter int CNT_W = DEFAULT_CNT_W
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             s0,
    input  logic             s1,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             a_valid,
    output logic             b_valid,
    output logic             c_valid,
    output logic             d_valid,
    input  logic             a_ready,
    input  logic             b_ready,
    input  logic             c_ready,
    input  logic             d_ready,
    output logic             sel_err
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic [CNT_W-1:0] cnt_c,
    output logic [CNT_W-1:0] cnt_d
`endif
);

    logic [1:0]            w_sel;
    logic [3:0]            w_push;
    logic [3:0]            w_valid;
    logic [3:0]            w_ready;
    logic [3:0][WIDTH-1:0] w_data;
    logic [1:0]            r_prev_sel;
    logic                  r_prev_stall;
    logic                  r_sel_err;
`ifdef DEMUX_CNT_EN
    logic [3:0][CNT_W-1:0] w_cnt;
`endif

    assign w_sel    = {s0, s1};
    assign w_ready  = {d_ready, c_ready, b_ready, a_ready};
    assign in_ready = !w_valid[w_sel] || w_ready[w_sel];

    always_comb begin
        w_push = '0;
        if (in_valid && in_ready) begin
            w_push[w_sel] = 1'b1;
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_slot
        demux_slot #(
            .WIDTH (WIDTH)
`ifdef DEMUX_CNT_EN
            ,
            .CNT_W (CNT_W)
`endif
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .i_push  (w_push[k]),
            .i_ready (w_ready[k]),
            .i_data  (in_data),
            .o_data  (w_data[k]),
            .o_valid (w_valid[k])
`ifdef DEMUX_CNT_EN
            ,
            .o_cnt   (w_cnt[k])
`endif
        );
    end

    // A stalled producer must hold its select; moving it flags a violation
    // but routing still follows the live select.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_stall <= 1'b0;
            r_prev_sel   <= CH_A;
            r_sel_err    <= 1'b0;
        end else begin
            r_prev_stall <= in_valid && !in_ready;
            r_prev_sel   <= w_sel;
            if (in_valid && r_prev_stall && (w_sel != r_prev_sel)) begin
                r_sel_err <= 1'b1;
            end
        end
    end

    assign sel_err = r_sel_err;

    assign a       = w_data[CH_A];
    assign b       = w_data[CH_B];
    assign c       = w_data[CH_C];
    assign d       = w_data[CH_D];
    assign a_valid = w_valid[CH_A];
    assign b_valid = w_valid[CH_B];
    assign c_valid = w_valid[CH_C];
    assign d_valid = w_valid[CH_D];

`ifdef DEMUX_CNT_EN
    assign cnt_a = w_cnt[CH_A];
    assign cnt_b = w_cnt[CH_B];
    assign cnt_c = w_cnt[CH_C];
    assign cnt_d = w_cnt[CH_D];
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux_1to4_stream.sv
// ============================================================================
// Module  : tb_demux_1to4_stream
// Brief   : Scoreboard bench: per-channel expected-word queues model the slots.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_demux_1to4_stream;

    localparam int WIDTH = 2;
`ifdef DEMUX_CNT_EN
    localparam int CNT_W = 2;
`endif

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             s0;
    logic             s1;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b, c, d;
    logic             a_valid, b_valid, c_valid, d_valid;
    logic [3:0]       rdy;
    logic             sel_err;
`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt_a, cnt_b, cnt_c, cnt_d;
`endif

    demux_1to4_stream #(
        .WIDTH (WIDTH)
`ifdef DEMUX_CNT_EN
        ,
        .CNT_W (CNT_W)
`endif
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .s0       (s0),
        .s1       (s1),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .a_valid  (a_valid),
        .b_valid  (b_valid),
        .c_valid  (c_valid),
        .d_valid  (d_valid),
        .a_ready  (rdy[0]),
        .b_ready  (rdy[1]),
        .c_ready  (rdy[2]),
        .d_ready  (rdy[3]),
        .sel_err  (sel_err)
`ifdef DEMUX_CNT_EN
        ,
        .cnt_a    (cnt_a),
        .cnt_b    (cnt_b),
        .cnt_c    (cnt_c),
        .cnt_d    (cnt_d)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] dout [4];
    logic [3:0]       vld;
    assign dout[0] = a;
    assign dout[1] = b;
    assign dout[2] = c;
    assign dout[3] = d;
    assign vld     = {d_valid, c_valid, b_valid, a_valid};

    logic [WIDTH-1:0] q [4][$];
    int               exp_cnt [4];
    logic             exp_err;
    logic             prev_stall;
    logic [1:0]       prev_sel;
    int               n_checks;
    int               n_errors;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [WIDTH-1:0] dat);
        in_valid = v;
        {s0, s1} = sel;
        in_data  = dat;
    endtask

    // Check the settled state, then advance the model across the coming edge.
    task automatic step();
        logic [1:0] sel;
        logic       exp_rdy;
        #1;
        sel = {s0, s1};
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                q[k].delete();
                exp_cnt[k] = 0;
            end
            exp_err    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("valid[%0d]", k), 32'(vld[k]), 32'(q[k].size() != 0));
                if (q[k].size() != 0)
                    chk($sformatf("data[%0d]", k), 32'(dout[k]), 32'(q[k][0]));
            end
            exp_rdy = (q[sel].size() == 0) || rdy[sel];
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("sel_err", 32'(sel_err), 32'(exp_err));
`ifdef DEMUX_CNT_EN
            chk("cnt_a", 32'(cnt_a), 32'(exp_cnt[0] % (1 << CNT_W)));
            chk("cnt_b", 32'(cnt_b), 32'(exp_cnt[1] % (1 << CNT_W)));
            chk("cnt_c", 32'(cnt_c), 32'(exp_cnt[2] % (1 << CNT_W)));
            chk("cnt_d", 32'(cnt_d), 32'(exp_cnt[3] % (1 << CNT_W)));
`endif
            if (in_valid && prev_stall && (sel != prev_sel))
                exp_err = 1'b1;
            prev_stall = in_valid && !exp_rdy;
            prev_sel   = sel;
            for (int k = 0; k < 4; k++) begin
                if (q[k].size() != 0 && rdy[k]) begin
                    void'(q[k].pop_front());
                    exp_cnt[k]++;
                end
            end
            if (in_valid && exp_rdy)
                q[sel].push_back(in_data);
        end
        @(negedge clk);
    endtask

    task automatic check_reset();
        #1;
        chk("rst_valid", 32'(vld), 32'h0);
        chk("rst_a", 32'(a), 32'h0);
        chk("rst_b", 32'(b), 32'h0);
        chk("rst_c", 32'(c), 32'h0);
        chk("rst_d", 32'(d), 32'h0);
        chk("rst_sel_err", 32'(sel_err), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        exp_err    = 1'b0;
        prev_stall = 1'b0;
        prev_sel   = 2'b00;
        rst        = 1'b1;
        rdy        = 4'hF;
        drive(1'b0, 2'b00, 2'b00);
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        check_reset();

        // Single push to b with all readies high.
        drive(1'b1, 2'b01, 2'b10);
        step();
        drive(1'b0, 2'b00, 2'b00);
        step();
        step();

        // Stall on a, then release: pop and reload on one edge.
        rdy = 4'hE;
        drive(1'b1, 2'b00, 2'b01);
        step();
        drive(1'b1, 2'b00, 2'b11);
        step();
        step();
        rdy = 4'hF;
        step();
        drive(1'b0, 2'b00, 2'b00);
        step();
        step();

        // Back-to-back stream on d.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b11, 2'(i));
            step();
        end
        drive(1'b0, 2'b00, 2'b00);
        step();
        step();

        // Stall on a, then retarget the stalled word to c.
        rdy = 4'hE;
        drive(1'b1, 2'b00, 2'b01);
        step();
        drive(1'b1, 2'b00, 2'b10);
        step();
        drive(1'b1, 2'b10, 2'b10);
        step();
        drive(1'b0, 2'b00, 2'b00);
        step();
        step();

        // Drain, fill every slot, then reset mid-transfer.
        rdy = 4'hF;
        step();
        rdy = 4'h0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'(k), 2'(3 - k));
            step();
        end
        drive(1'b0, 2'b00, 2'b00);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset();
        rdy = 4'hF;
        step();
        step();

        // Five pops on b exercise counter wrap.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'b01, 2'(i));
            step();
        end
        drive(1'b0, 2'b00, 2'b00);
        step();
        step();

        // Random traffic with independent consumer stalls.
        for (int i = 0; i < 80; i++) begin
            rdy = 4'($urandom_range(0, 15));
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            step();
        end
        drive(1'b0, 2'b00, 2'b00);
        rdy = 4'hF;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
